// File: rtl/read_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : read_issuer_if
// Description : Bus bundle for the read issuer. It carries three groups of
//               signals: the command handshake, the Avalon-MM read request,
//               and the compare-descriptor side channel.
//               modport master : the issuer's view (drives *_o, samples *_i)
//               modport slave  : the surrounding logic's view
//               Port summary (suffix gives direction seen by the issuer):
//                 cmd_*      command offer / accept
//                 amm_*      AMM read request, stall and returned beats
//                 cmp_*      descriptor pulse plus comparator feedback
//                 busy_o     burst in flight or pending
// Revision    : 1.0 - initial release
// ============================================================================
interface read_issuer_if #(
    parameter int ADDR_W  = 32,
    parameter int BURST_W = 7
) ();
    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic [ADDR_W-1:0]    cmd_addr_i;
    logic [BURST_W-2:0]   cmd_words_i;
    logic [7:0]           cmd_ptrn_i;
    logic                 cmd_rnd_i;

    logic [ADDR_W-1:0]    amm_address_o;
    logic                 amm_read_o;
    logic [BURST_W-1:0]   amm_burstcount_o;
    logic                 amm_waitrequest_i;
    logic                 amm_readdatavalid_i;

    logic                 cmp_en_o;
    logic [ADDR_W-1:0]    cmp_addr_o;
    logic [BURST_W-2:0]   cmp_words_o;
    logic [7:0]           cmp_ptrn_o;
    logic                 cmp_rnd_o;
    logic                 cmp_done_i;
    logic                 cmp_error_i;

    logic                 busy_o;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_words_i, cmd_ptrn_i, cmd_rnd_i,
        output cmd_ready_o,
        output amm_address_o, amm_read_o, amm_burstcount_o,
        input  amm_waitrequest_i, amm_readdatavalid_i,
        output cmp_en_o, cmp_addr_o, cmp_words_o, cmp_ptrn_o, cmp_rnd_o,
        input  cmp_done_i, cmp_error_i,
        output busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_words_i, cmd_ptrn_i, cmd_rnd_i,
        input  cmd_ready_o,
        input  amm_address_o, amm_read_o, amm_burstcount_o,
        output amm_waitrequest_i, amm_readdatavalid_i,
        input  cmp_en_o, cmp_addr_o, cmp_words_o, cmp_ptrn_o, cmp_rnd_o,
        output cmp_done_i, cmp_error_i,
        input  busy_o
    );
endinterface
`default_nettype wire

// File: rtl/read_issuer.sv
`default_nettype none
// ============================================================================
// Module      : read_issuer
// Description : Accepts read commands and issues each one as a single AMM
//               burst read. After the slave accepts the burst, the issuer
//               pulses a compare descriptor for one cycle. New commands are
//               throttled so that outstanding beats and outstanding bursts
//               never exceed the downstream buffer depths. A comparator
//               error parks the block in HALT until start_test_i.
// Ports       : clk_i, rst_i (async, active-high), start_test_i (sync clear),
//               bus (read_issuer_if.master: cmd_*, amm_*, cmp_*, busy_o)
// Revision    : 1.0 - initial release
// ============================================================================
module read_issuer #(
    parameter int ADDR_W     = 32,
    parameter int BURST_W    = 7,
    parameter int MAX_BEATS  = 64,
    parameter int MAX_BURSTS = 4
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    input  wire logic       start_test_i,
    read_issuer_if.master   bus
);
    localparam int CNT_W  = $clog2(MAX_BEATS) + 1;
    localparam int BCNT_W = $clog2(MAX_BURSTS) + 1;
    // Wide enough to hold beats_out + a full burst without wrapping.
    localparam int SUM_W  = ((CNT_W > BURST_W) ? CNT_W : BURST_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [ADDR_W-1:0]    r_addr;
    logic [BURST_W-2:0]   r_words;
    logic [7:0]           r_ptrn;
    logic                 r_rnd;
    logic [BURST_W-1:0]   r_burstcount;
    logic                 r_cmp_en;
    logic                 r_busy;
    logic                 r_err_seen;
    logic [CNT_W-1:0]     r_beats_out;
    logic [BCNT_W-1:0]    r_bursts_out;

    logic                 w_cmd_ok;
    logic                 w_cmd_accept;
    logic                 w_amm_accept;
    logic                 w_err_seen_next;
    logic [SUM_W-1:0]     w_beats_need;
    logic [SUM_W-1:0]     w_beats_sum;
    logic [CNT_W-1:0]     w_beats_next;
    logic [BCNT_W-1:0]    w_bursts_next;

    // Room check uses the live command length so a command that fits is
    // accepted in the same cycle it is offered. start_test_i masks the
    // accept so that a command is never acknowledged and then dropped.
    assign w_beats_need = SUM_W'(r_beats_out) + SUM_W'(bus.cmd_words_i) + SUM_W'(1);
    assign w_cmd_ok     = bus.cmd_valid_i && !bus.cmp_error_i && !start_test_i
                          && (w_beats_need <= SUM_W'(MAX_BEATS))
                          && (r_bursts_out < BCNT_W'(MAX_BURSTS));
    assign w_amm_accept = (r_state == S_REQ) && !bus.amm_waitrequest_i;

    always_comb begin
        w_next_state    = r_state;
        w_cmd_accept    = 1'b0;
        w_err_seen_next = r_err_seen;
        case (r_state)
            S_IDLE: begin
                w_err_seen_next = 1'b0;
                if (bus.cmp_error_i) begin
                    w_next_state = S_HALT;
                end else if (w_cmd_ok) begin
                    w_cmd_accept = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                // An error seen while stalled must not abort the AMM
                // handshake, so it is remembered until the slave accepts.
                if (bus.cmp_error_i) begin
                    w_err_seen_next = 1'b1;
                end
                if (w_amm_accept) begin
                    w_next_state    = (r_err_seen || bus.cmp_error_i) ? S_HALT : S_IDLE;
                    w_err_seen_next = 1'b0;
                end
            end
            S_HALT: begin
                w_err_seen_next = 1'b0;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (start_test_i) begin
            w_next_state    = S_IDLE;
            w_cmd_accept    = 1'b0;
            w_err_seen_next = 1'b0;
        end
    end

    // Net beat accounting: add the accepted burst, then retire one returned
    // beat, clamping at zero if a stray beat arrives with nothing owed.
    always_comb begin
        w_beats_sum   = SUM_W'(r_beats_out) + (w_amm_accept ? SUM_W'(r_burstcount) : '0);
        w_beats_next  = CNT_W'(w_beats_sum);
        if (bus.amm_readdatavalid_i && (w_beats_sum != '0)) begin
            w_beats_next = CNT_W'(w_beats_sum - SUM_W'(1));
        end
        w_bursts_next = r_bursts_out;
        if (w_amm_accept && !bus.cmp_done_i) begin
            w_bursts_next = r_bursts_out + BCNT_W'(1);
        end else if (!w_amm_accept && bus.cmp_done_i && (r_bursts_out != '0)) begin
            w_bursts_next = r_bursts_out - BCNT_W'(1);
        end
        if (start_test_i) begin
            w_beats_next  = '0;
            w_bursts_next = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr       <= '0;
            r_words      <= '0;
            r_ptrn       <= '0;
            r_rnd        <= 1'b0;
            r_burstcount <= '0;
            r_cmp_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_err_seen   <= 1'b0;
            r_beats_out  <= '0;
            r_bursts_out <= '0;
        end else begin
            if (w_cmd_accept) begin
                r_addr       <= bus.cmd_addr_i;
                r_words      <= bus.cmd_words_i;
                r_ptrn       <= bus.cmd_ptrn_i;
                r_rnd        <= bus.cmd_rnd_i;
                r_burstcount <= BURST_W'(bus.cmd_words_i) + BURST_W'(1);
            end
            r_cmp_en     <= w_amm_accept && !start_test_i;
            r_err_seen   <= w_err_seen_next;
            r_beats_out  <= w_beats_next;
            r_bursts_out <= w_bursts_next;
            r_busy       <= (w_next_state == S_REQ) || (w_bursts_next != '0);
        end
    end

    // The descriptor reuses the command registers. The next command can only
    // load in the same cycle the pulse is shown, so the fields stay valid.
    assign bus.cmd_ready_o      = w_cmd_accept;
    assign bus.amm_read_o       = (r_state == S_REQ);
    assign bus.amm_address_o    = r_addr;
    assign bus.amm_burstcount_o = r_burstcount;
    assign bus.cmp_en_o         = r_cmp_en;
    assign bus.cmp_addr_o       = r_addr;
    assign bus.cmp_words_o      = r_words;
    assign bus.cmp_ptrn_o       = r_ptrn;
    assign bus.cmp_rnd_o        = r_rnd;
    assign bus.busy_o           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_read_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_read_issuer
// Description : Self-checking bench for read_issuer. A transaction-level
//               model tracks owed beats, open descriptors, the pending
//               request and the halt condition, and predicts every output
//               each cycle. Directed scenarios cover the documented corner
//               cases, followed by a randomized soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_read_issuer;
    localparam int ADDR_W     = 32;
    localparam int BURST_W    = 7;
    localparam int MAX_BEATS  = 64;
    localparam int MAX_BURSTS = 4;

    logic clk = 1'b0;
    logic rst;
    logic start_test;
    always #5 clk = ~clk;

    read_issuer_if #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

    read_issuer #(
        .ADDR_W(ADDR_W), .BURST_W(BURST_W),
        .MAX_BEATS(MAX_BEATS), .MAX_BURSTS(MAX_BURSTS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_test_i(start_test),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stimulus for the next cycle.
    bit          d_valid, d_rnd, d_wait, d_rdv, d_done, d_err, d_st;
    logic [31:0] d_addr;
    logic [5:0]  d_words;
    logic [7:0]  d_ptrn;

    // Reference model state.
    int          m_beats, m_bursts;
    bit          m_req, m_halted, m_err, m_pulse, m_busy;
    logic [31:0] m_addr, p_addr;
    logic [5:0]  m_words, p_words;
    logic [7:0]  m_ptrn, p_ptrn;
    bit          m_rnd, p_rnd;

    task automatic model_clear();
        m_beats = 0; m_bursts = 0;
        m_req = 0; m_halted = 0; m_err = 0; m_pulse = 0; m_busy = 0;
    endtask

    task automatic clr();
        d_valid = 0; d_rnd = 0; d_wait = 0; d_rdv = 0; d_done = 0; d_err = 0; d_st = 0;
        d_addr = '0; d_words = '0; d_ptrn = '0;
    endtask

    task automatic offer(input logic [31:0] a, input logic [5:0] w);
        clr();
        d_valid = 1; d_addr = a; d_words = w; d_ptrn = 8'h5A; d_rnd = 1;
    endtask

    // One clock: apply stimulus, compare all outputs with the model, then
    // advance the model by the events that occur at the coming edge.
    task automatic tick();
        bit exp_ready, acc;
        int nb;
        @(negedge clk);
        bus.cmd_valid_i         = d_valid;
        bus.cmd_addr_i          = d_addr;
        bus.cmd_words_i         = d_words;
        bus.cmd_ptrn_i          = d_ptrn;
        bus.cmd_rnd_i           = d_rnd;
        bus.amm_waitrequest_i   = d_wait;
        bus.amm_readdatavalid_i = d_rdv;
        bus.cmp_done_i          = d_done;
        bus.cmp_error_i         = d_err;
        start_test              = d_st;
        #1;
        exp_ready = !m_req && !m_halted && d_valid && !d_err && !d_st
                    && (m_beats + int'(d_words) + 1 <= MAX_BEATS) && (m_bursts < MAX_BURSTS);
        check("cmd_ready", 64'(bus.cmd_ready_o), 64'(exp_ready));
        check("amm_read", 64'(bus.amm_read_o), 64'(m_req));
        if (m_req) begin
            check("amm_address", 64'(bus.amm_address_o), 64'(m_addr));
            check("amm_burstcount", 64'(bus.amm_burstcount_o), 64'(m_words) + 64'd1);
        end
        check("cmp_en", 64'(bus.cmp_en_o), 64'(m_pulse));
        if (m_pulse) begin
            check("cmp_addr", 64'(bus.cmp_addr_o), 64'(p_addr));
            check("cmp_words", 64'(bus.cmp_words_o), 64'(p_words));
            check("cmp_ptrn", 64'(bus.cmp_ptrn_o), 64'(p_ptrn));
            check("cmp_rnd", 64'(bus.cmp_rnd_o), 64'(p_rnd));
        end
        check("busy", 64'(bus.busy_o), 64'(m_busy));
        check("beats_out", 64'(dut.r_beats_out), 64'(m_beats));
        check("bursts_out", 64'(dut.r_bursts_out), 64'(m_bursts));

        if (d_st) begin
            model_clear();
        end else begin
            acc     = m_req && !d_wait;
            m_pulse = acc;
            if (acc) begin
                p_addr = m_addr; p_words = m_words; p_ptrn = m_ptrn; p_rnd = m_rnd;
            end
            nb      = m_beats + (acc ? int'(m_words) + 1 : 0) - (d_rdv ? 1 : 0);
            m_beats = (nb < 0) ? 0 : nb;
            if (acc && !d_done) m_bursts++;
            else if (d_done && !acc && m_bursts > 0) m_bursts--;
            if (m_req) begin
                if (d_err) m_err = 1;
                if (acc) begin
                    m_req    = 0;
                    m_halted = m_err;
                    m_err    = 0;
                end
            end else if (!m_halted) begin
                if (d_err) begin
                    m_halted = 1;
                end else if (exp_ready) begin
                    m_req = 1;
                    m_addr = d_addr; m_words = d_words; m_ptrn = d_ptrn; m_rnd = d_rnd;
                end
            end
            m_busy = m_req || (m_bursts != 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_amm_read", 64'(bus.amm_read_o), 64'd0);
        check("rst_cmp_en", 64'(bus.cmp_en_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_amm_address", 64'(bus.amm_address_o), 64'd0);
        check("rst_burstcount", 64'(bus.amm_burstcount_o), 64'd0);
        check("rst_cmp_addr", 64'(bus.cmp_addr_o), 64'd0);
        check("rst_cmp_words", 64'(bus.cmp_words_o), 64'd0);
        check("rst_cmp_ptrn", 64'(bus.cmp_ptrn_o), 64'd0);
        check("rst_cmp_rnd", 64'(bus.cmp_rnd_o), 64'd0);
        check("rst_beats", 64'(dut.r_beats_out), 64'd0);
        check("rst_bursts", 64'(dut.r_bursts_out), 64'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_read, n_en;
        rst = 1'b1;
        start_test = 1'b0;
        clr();
        bus.cmd_valid_i = 0; bus.cmd_addr_i = '0; bus.cmd_words_i = '0;
        bus.cmd_ptrn_i = '0; bus.cmd_rnd_i = 0; bus.amm_waitrequest_i = 0;
        bus.amm_readdatavalid_i = 0; bus.cmp_done_i = 0; bus.cmp_error_i = 0;
        do_reset();

        // 4-beat read at 0x100, no stall
        clr(); d_st = 1; tick();
        offer(32'h100, 6'd3); tick();
        check("r21_ready", 64'(bus.cmd_ready_o), 64'd1);
        clr(); tick();
        check("r21_read", 64'(bus.amm_read_o), 64'd1);
        check("r21_bc", 64'(bus.amm_burstcount_o), 64'd4);
        tick();
        check("r21_read_drop", 64'(bus.amm_read_o), 64'd0);
        check("r21_cmp_en", 64'(bus.cmp_en_o), 64'd1);
        check("r21_cmp_addr", 64'(bus.cmp_addr_o), 64'h100);
        check("r21_cmp_words", 64'(bus.cmp_words_o), 64'd3);
        check("r21_beats4", 64'(dut.r_beats_out), 64'd4);
        d_rdv = 1; repeat (4) tick();
        d_rdv = 0; d_done = 1; tick();
        check("r21_beats0", 64'(dut.r_beats_out), 64'd0);
        clr(); tick();

        // Five cycles of waitrequest: six request cycles, one descriptor
        clr(); d_st = 1; tick();
        offer(32'h2000, 6'd7); tick();
        clr(); n_read = 0; n_en = 0;
        d_wait = 1;
        repeat (5) begin tick(); n_read += int'(bus.amm_read_o); n_en += int'(bus.cmp_en_o); end
        d_wait = 0;
        repeat (3) begin tick(); n_read += int'(bus.amm_read_o); n_en += int'(bus.cmp_en_o); end
        check("r22_read_cycles", 64'(n_read), 64'd6);
        check("r22_cmp_pulses", 64'(n_en), 64'd1);

        // Burst budget: fifth command waits for a cmp_done
        clr(); d_st = 1; tick();
        for (int k = 0; k < 4; k++) begin
            offer(32'(k), 6'd0); tick();
            clr(); tick();
        end
        offer(32'h44, 6'd0); tick();
        check("r23_stall_a", 64'(bus.cmd_ready_o), 64'd0);
        tick();
        check("r23_stall_b", 64'(bus.cmd_ready_o), 64'd0);
        d_done = 1; tick();
        d_done = 0; tick();
        check("r23_accept", 64'(bus.cmd_ready_o), 64'd1);
        clr(); tick(); tick();

        // Beat budget: 63 beats then 2 beats
        clr(); d_st = 1; tick();
        offer(32'h300, 6'd62); tick();
        clr(); tick();
        offer(32'h400, 6'd1); tick();
        check("r24_stall_a", 64'(bus.cmd_ready_o), 64'd0);
        tick();
        check("r24_stall_b", 64'(bus.cmd_ready_o), 64'd0);
        d_rdv = 1; tick();
        d_rdv = 0; tick();
        check("r24_accept", 64'(bus.cmd_ready_o), 64'd1);
        clr(); tick(); tick();

        // Error while stalled in REQ: handshake completes, then HALT
        clr(); d_st = 1; tick();
        offer(32'h500, 6'd1); tick();
        clr(); d_wait = 1; d_err = 1; tick(); tick();
        d_err = 0; tick();
        check("r25_still_reading", 64'(bus.amm_read_o), 64'd1);
        d_wait = 0; tick();
        offer(32'h600, 6'd0);
        repeat (3) begin tick(); check("r25_halt_noready", 64'(bus.cmd_ready_o), 64'd0); end
        d_st = 1; tick();
        d_st = 0; tick();
        check("r25_ready_after_start", 64'(bus.cmd_ready_o), 64'd1);
        clr(); tick(); tick();

        // Accept a 2-beat burst in the same cycle as a returned beat
        clr(); d_st = 1; tick();
        offer(32'h700, 6'd2); tick();
        clr(); tick();
        offer(32'h800, 6'd1); tick();
        check("r26_beats3", 64'(dut.r_beats_out), 64'd3);
        clr(); d_rdv = 1; tick();
        clr(); tick();
        check("r26_beats4", 64'(dut.r_beats_out), 64'd4);

        // Reset in the middle of a stalled request
        clr(); d_st = 1; tick();
        offer(32'h900, 6'd5); tick();
        clr(); d_wait = 1; tick();
        check("r20_reading", 64'(bus.amm_read_o), 64'd1);
        do_reset();
        clr(); n_en = 0;
        repeat (3) begin tick(); n_en += int'(bus.cmp_en_o); end
        check("r20_no_cmp_en", 64'(n_en), 64'd0);

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            d_valid = ($urandom_range(0, 1) == 1);
            d_addr  = $urandom;
            case ($urandom_range(0, 3))
                0:       d_words = 6'd0;
                1:       d_words = 6'($urandom_range(0, 3));
                2:       d_words = 6'($urandom_range(60, 63));
                default: d_words = 6'($urandom);
            endcase
            d_ptrn = 8'($urandom);
            d_rnd  = ($urandom_range(0, 1) == 1);
            d_wait = ($urandom_range(0, 9) < 4);
            d_rdv  = (m_beats > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
            d_done = (m_bursts > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            d_err  = ($urandom_range(0, 99) == 0);
            d_st   = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
